// File: rtl/jpeg_data_to_spi.sv
`default_nettype none
// ============================================================================
// Module   : jpeg_data_to_spi
// Purpose  : Streams the JPEG header ROM, then the encoded scan data up to EOI,
//            one byte per SPI read request.
// Revision : 1.0  initial release
// ============================================================================
module jpeg_data_to_spi #(
  parameter int          HEADER_LEN = 623,
  parameter logic [16:0] MEM_LAST   = 17'h1FFFF
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        je_done,
  output logic [9:0]  hd_addr,
  input  logic [7:0]  hd_data,
  output logic [16:0] je_addr,
  input  logic [7:0]  je_data,
  input  logic        spi_rd,
  output logic [7:0]  spi_data
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_HDR  = 2'd1,
    S_DATA = 2'd2,
    S_DONE = 2'd3
  } state_t;

  localparam logic [9:0] c_hd_last = 10'(HEADER_LEN - 1);

  state_t      r_state;
  logic        r_je_done_d;
  logic        r_fetch_addr;
  logic        r_fetch_data;
  logic [9:0]  r_hd_ptr;
  logic [16:0] r_je_ptr;
  logic [7:0]  r_spi_data;
  logic [7:0]  r_hist;

  logic w_arm;
  logic w_busy;
  logic w_rd;
  logic w_eoi;

  assign w_arm  = je_done & ~r_je_done_d;
  assign w_busy = r_fetch_addr | r_fetch_data;
  assign w_rd   = spi_rd & ~w_busy;
  assign w_eoi  = (r_spi_data == 8'hD9) && (r_hist == 8'hFF);

  assign hd_addr  = r_hd_ptr;
  assign je_addr  = r_je_ptr;
  assign spi_data = r_spi_data;

  // r_fetch_addr: memory is sampling the pointer; r_fetch_data: read data is ready.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= S_IDLE;
      r_je_done_d  <= 1'b0;
      r_fetch_addr <= 1'b0;
      r_fetch_data <= 1'b0;
      r_hd_ptr     <= 10'd0;
      r_je_ptr     <= 17'd0;
      r_spi_data   <= 8'h00;
      r_hist       <= 8'h00;
    end else begin
      r_je_done_d  <= je_done;
      r_fetch_data <= r_fetch_addr;
      r_fetch_addr <= 1'b0;

      if (r_fetch_data && !w_arm) begin
        r_spi_data <= (r_state == S_DATA) ? je_data : hd_data;
      end

      // A restart cancels any fetch in flight and takes priority over spi_rd.
      if (w_arm) begin
        r_state      <= S_HDR;
        r_hd_ptr     <= 10'd0;
        r_hist       <= 8'h00;
        r_fetch_addr <= 1'b1;
        r_fetch_data <= 1'b0;
      end else if (w_rd) begin
        case (r_state)
          S_HDR: begin
            r_fetch_addr <= 1'b1;
            if (r_hd_ptr == c_hd_last) begin
              r_state  <= S_DATA;
              r_je_ptr <= 17'd0;
              r_hist   <= 8'h00;
            end else begin
              r_hd_ptr <= r_hd_ptr + 10'd1;
            end
          end
          S_DATA: begin
            if (w_eoi || (r_je_ptr == MEM_LAST)) begin
              r_state    <= S_DONE;
              r_spi_data <= 8'h00;
            end else begin
              r_je_ptr     <= r_je_ptr + 17'd1;
              r_hist       <= r_spi_data;
              r_fetch_addr <= 1'b1;
            end
          end
          default: begin
          end
        endcase
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_jpeg_data_to_spi.sv
`default_nettype none
// ============================================================================
// Module   : tb_jpeg_data_to_spi
// Purpose  : Self-checking bench for jpeg_data_to_spi against a stream model.
// Revision : 1.0  initial release
// ============================================================================
module tb_jpeg_data_to_spi;

  localparam int          HL    = 623;
  localparam logic [16:0] ML    = 17'h003FF;
  localparam int          MEM_N = 1024;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        je_done;
  logic        spi_rd;
  logic [9:0]  hd_addr;
  logic [7:0]  hd_data;
  logic [16:0] je_addr;
  logic [7:0]  je_data;
  logic [7:0]  spi_data;

  logic [7:0] mem [0:MEM_N-1];

  int checks   = 0;
  int failures = 0;
  bit chk_en   = 1'b0;

  jpeg_data_to_spi #(.HEADER_LEN(HL), .MEM_LAST(ML)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .je_done  (je_done),
    .hd_addr  (hd_addr),
    .hd_data  (hd_data),
    .je_addr  (je_addr),
    .je_data  (je_data),
    .spi_rd   (spi_rd),
    .spi_data (spi_data)
  );

  always #5 clk = ~clk;

  // Synchronous-read header ROM (ROM[i] = i[7:0]) and frame memory.
  always @(posedge clk) begin
    hd_data <= hd_addr[7:0];
    je_data <= mem[je_addr[9:0]];
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Expected transfer = header bytes, then scan bytes through the first FF D9 or MEM_LAST.
  function automatic int data_len();
    for (int k = 1; k < MEM_N; k++)
      if (mem[k-1] == 8'hFF && mem[k] == 8'hD9) return k + 1;
    return MEM_N;
  endfunction

  function automatic logic [7:0] stream_byte(input int p);
    if (p < HL) return 8'(p);
    return mem[p - HL];
  endfunction

  task automatic fill_random();
    for (int i = 0; i < MEM_N; i++) mem[i] = 8'($urandom);
    for (int k = 1; k < MEM_N; k++)
      if (mem[k-1] == 8'hFF && mem[k] == 8'hD9) mem[k] = 8'h00;
  endtask

  // ---------------- behavioural model ----------------
  int          m_pos, m_len, m_pend;
  bit          m_active, m_jd_q, m_je_valid, m_arm, m_busy;
  logic [7:0]  m_pend_val;
  logic [7:0]  exp_spi;
  logic [9:0]  exp_hd;
  logic [16:0] exp_je;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_jd_q = 1'b0; m_active = 1'b0; m_pend = 0; m_je_valid = 1'b1;
      exp_spi = 8'h00; exp_hd = 10'd0; exp_je = 17'd0;
    end else begin
      m_arm  = je_done && !m_jd_q;
      m_jd_q = je_done;
      m_busy = (m_pend != 0);
      if (m_arm) begin
        m_active = 1'b1; m_pos = 0; m_len = HL + data_len();
        m_pend = 2; m_pend_val = stream_byte(0);
        exp_hd = 10'd0; m_je_valid = 1'b0;
      end else begin
        if (m_pend > 0) begin
          m_pend--;
          if (m_pend == 0) exp_spi = m_pend_val;
        end
        if (spi_rd && m_active && !m_busy) begin
          if (m_pos == m_len - 1) begin
            m_active = 1'b0;
            exp_spi  = 8'h00;
          end else begin
            m_pos++;
            m_pend = 2; m_pend_val = stream_byte(m_pos);
            if (m_pos < HL) exp_hd = 10'(m_pos);
            else begin exp_je = 17'(m_pos - HL); m_je_valid = 1'b1; end
          end
        end
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("spi_data", 32'(spi_data), 32'(exp_spi));
      check("hd_addr", 32'(hd_addr), 32'(exp_hd));
      if (m_je_valid) check("je_addr", 32'(je_addr), 32'(exp_je));
    end
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic rd(input int gap);
    spi_rd = 1'b1;
    step();
    spi_rd = 1'b0;
    repeat (gap - 1) step();
  endtask

  task automatic pulse_arm();
    je_done = 1'b1;
    step();
    je_done = 1'b0;
    step();
    step();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int k;
    reset_n = 1'b0; je_done = 1'b0; spi_rd = 1'b0;
    fill_random();
    repeat (3) @(posedge clk);
    #2;
    chk_en  = 1'b1;
    reset_n = 1'b1;
    check("lit_reset_spi", 32'(spi_data), 32'h00);
    check("lit_reset_hd", 32'(hd_addr), 32'h0);
    check("lit_reset_je", 32'(je_addr), 32'h0);
    step(); step();

    // Header walk, then scan data 12 FF 00 34 FF D9.
    mem[0] = 8'h12; mem[1] = 8'hFF; mem[2] = 8'h00;
    mem[3] = 8'h34; mem[4] = 8'hFF; mem[5] = 8'hD9;
    pulse_arm();
    check("lit_hdr0_spi", 32'(spi_data), 32'h00);
    check("lit_hdr0_hd", 32'(hd_addr), 32'h0);
    for (int i = 1; i <= 5; i++) rd(3);
    check("lit_hdr5_spi", 32'(spi_data), 32'h05);
    for (int i = 6; i < HL; i++) rd(3);
    check("lit_hdr622_spi", 32'(spi_data), 32'h6E);
    check("lit_hdr622_hd", 32'(hd_addr), 32'd622);
    rd(3);
    check("lit_data0_je", 32'(je_addr), 32'h0);
    check("lit_data0_spi", 32'(spi_data), 32'h12);
    rd(3); check("lit_data1_spi", 32'(spi_data), 32'hFF);
    rd(3); check("lit_data2_spi", 32'(spi_data), 32'h00);
    rd(3); check("lit_data3_spi", 32'(spi_data), 32'h34);
    rd(3); check("lit_data4_spi", 32'(spi_data), 32'hFF);
    rd(3); check("lit_data5_spi", 32'(spi_data), 32'hD9);
    rd(3); check("lit_eoi_done_spi", 32'(spi_data), 32'h00);
    rd(3); rd(3);
    check("lit_done_je_hold", 32'(je_addr), 32'h5);

    // Restart at je_addr 100 coincident with spi_rd, then run to MEM_LAST with je_done held high.
    fill_random();
    pulse_arm();
    repeat (HL + 100) rd(3);
    check("lit_data100_je", 32'(je_addr), 32'd100);
    je_done = 1'b1; spi_rd = 1'b1;
    step();
    spi_rd = 1'b0;
    check("lit_restart_hd", 32'(hd_addr), 32'h0);
    step(); step();
    check("lit_restart_spi", 32'(spi_data), 32'h00);
    repeat (HL + MEM_N - 1) rd(3);
    check("lit_memlast_je", 32'(je_addr), 32'(ML));
    check("lit_memlast_spi", 32'(spi_data), 32'(mem[MEM_N-1]));
    rd(3);
    check("lit_memlast_done_spi", 32'(spi_data), 32'h00);
    check("lit_memlast_done_je", 32'(je_addr), 32'(ML));
    je_done = 1'b0;
    step();

    // Reset mid-DATA, reads ignored afterwards, then je_done high across reset release.
    pulse_arm();
    repeat (HL + 10) rd(3);
    reset_n = 1'b0;
    #1;
    check("lit_async_rst_spi", 32'(spi_data), 32'h00);
    check("lit_async_rst_je", 32'(je_addr), 32'h0);
    step(); step();
    reset_n = 1'b1;
    repeat (3) rd(3);
    check("lit_idle_ignore_spi", 32'(spi_data), 32'h00);
    check("lit_idle_ignore_hd", 32'(hd_addr), 32'h0);
    reset_n = 1'b0; je_done = 1'b1;
    step();
    reset_n = 1'b1;
    step(); step(); step();
    check("lit_rel_arm_hd", 32'(hd_addr), 32'h0);
    rd(3);
    check("lit_rel_arm_spi", 32'(spi_data), 32'h01);
    je_done = 1'b0;
    step();

    // Randomized transfers: random data, random EOI position, jittered reads, rare restarts.
    for (int t = 0; t < 3; t++) begin
      fill_random();
      k = $urandom_range(2, 300);
      mem[k-1] = 8'hFF; mem[k] = 8'hD9;
      pulse_arm();
      n = 0;
      while (m_active && n < 4000) begin
        if (n < 1000 && $urandom_range(0, 999) == 0) begin
          je_done = 1'b1; step(); je_done = 1'b0; step();
        end else begin
          rd($urandom_range(2, 6));
        end
        n++;
      end
      checks++;
      if (m_active) begin
        failures++;
        $display("FAIL rand_transfer_end: transfer %0d still active after %0d steps, required done", t, n);
      end
      rd(3);
      step();
    end

    chk_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/jpeg_data_to_spi.md
JPEG_DATA_TO_SPI -- requirements
Module: jpeg_data_to_spi

Interface
REQ-001 SHALL have parameter: HEADER_LEN, 623, number of JPEG header bytes (SOI through SOS) held in the external header ROM.
REQ-002 SHALL have parameter: MEM_LAST, 17'h1FFFF, last valid frame-memory byte address.
REQ-003 SHALL have port: clk  input  1  single clock; all logic rises on it.
REQ-004 SHALL have port: reset_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port: je_done  input  1  encoder finished; its rising edge arms a new image transfer.
REQ-006 SHALL have port: hd_addr  output  10  header ROM byte address.
REQ-007 SHALL have port: hd_data  input  8  header ROM data, valid 1 clk after hd_addr (synchronous read).
REQ-008 SHALL have port: je_addr  output  17  frame-memory read address of encoded scan data.
REQ-009 SHALL have port: je_data  input  8  frame-memory data, valid 1 clk after je_addr (synchronous read).
REQ-010 SHALL have port: spi_rd  input  1  one-clk pulse from SPI slave: current spi_data consumed, advance.
REQ-011 SHALL have port: spi_data  output  8  registered byte presented to the SPI slave.

Function
REQ-012 SHALL implement states IDLE, HDR, DATA, DONE.
REQ-013 SHALL detect the je_done rising edge with a registered copy of je_done; the edge arms from any state, including mid-stream, by entering HDR with header pointer 0.
REQ-014 SHALL drive hd_addr from the registered header pointer and je_addr from the registered data pointer, both as combinational copies of those registers.
REQ-015 SHALL load spi_data exactly 2 clk after any pointer load/increment: edge+1 memory samples the address, edge+2 spi_data <= hd_data (HDR) or je_data (DATA).
REQ-016 SHALL hold spi_data stable between loads.
REQ-017 SHALL ignore spi_rd while a fetch is pending; the SPI slave spaces pulses at least 3 clk apart.
REQ-018 SHALL, in HDR on spi_rd, increment the header pointer while it is below HEADER_LEN-1.
REQ-019 SHALL, in HDR on spi_rd at pointer HEADER_LEN-1, enter DATA with je_addr=0 and fetch frame byte 0.
REQ-020 SHALL, in DATA, keep a one-byte history of the last delivered byte.
REQ-021 SHALL, in DATA on spi_rd, enter DONE if the delivered byte is 8'hD9 and the previous delivered byte is 8'hFF (EOI), or if je_addr==MEM_LAST.
REQ-022 SHALL, in DATA on spi_rd when neither REQ-021 condition holds, increment je_addr.
REQ-023 SHALL clear the one-byte history on entry to DATA, so header bytes never form EOI.
REQ-024 SHALL, in DONE and IDLE, drive spi_data=8'h00 and ignore spi_rd until the next je_done rising edge.
REQ-025 SHALL, in HDR/DATA with je_done held high (level), not restart; only edges arm.
REQ-026 SHALL treat a simultaneous je_done edge and spi_rd as a je_done edge: restart wins.

Reset
REQ-027 SHALL, while reset_n=0, force state IDLE, hd_addr=0, je_addr=0, spi_data=8'h00, history=0, and je_done edge register=0.
REQ-028 SHALL count je_done already high at reset release as a rising edge on the first clock.
REQ-029 SHALL, on reset mid-transfer, abort the transfer immediately with no further memory fetches.

Verification
REQ-030 SHALL pass: reset, then je_done pulse, header ROM[i]=i[7:0] -> 2 clk later spi_data=8'h00 (ROM[0]); each spi_rd yields the next byte through index 622.
REQ-031 SHALL pass: after the 623rd spi_rd, with mem[0..3]=12,FF,00,34 -> je_addr=0, spi_data=8'h12, then 8'hFF, 8'h00, 8'h34; FF 00 does not terminate.
REQ-032 SHALL pass: mem[4..5]=FF,D9 -> both bytes delivered; the next spi_rd enters DONE and spi_data=8'h00; further spi_rd leave je_addr unchanged.
REQ-033 SHALL pass: no EOI in memory -> the stream runs to je_addr=17'h1FFFF, then DONE.
REQ-034 SHALL pass: je_done pulse while in DATA at je_addr=100 -> hd_addr=0, state HDR, spi_data=ROM[0] 2 clk later.
REQ-035 SHALL pass: reset_n low mid-DATA -> spi_data=8'h00 and je_addr=0 asynchronously; spi_rd is ignored until je_done.
